// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with input FIFO and internal baud enable
module uart_tx_param #(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(DEPTH);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, next_state;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    logic [CW-1:0]        baud_cnt;
    logic                 baud_tick;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;
    logic                 tx_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign push        = tx_valid && !full;
    assign head        = mem[rd_ptr[AW-1:0]];
    assign head_parity = (PARITY == 1) ? ~^head : ^head;
    assign baud_tick   = (baud_cnt == BAUD_LAST);

    assign tx_ready   = !full;
    assign tx         = tx_q;
    assign busy       = (state != S_IDLE);
    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = S_START;
                end
            end
            S_START: begin
                if (baud_tick) next_state = S_DATA;
            end
            S_DATA: begin
                if (baud_tick && bit_idx == DATA_LAST) begin
                    next_state = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_tick) next_state = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next start bit so queued frames have no idle gap.
                if (baud_tick && bit_idx == STOP_LAST) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = S_START;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (pop) begin
                shreg    <= head;
                par_q    <= head_parity;
                baud_cnt <= '0;
                bit_idx  <= '0;
                tx_q     <= 1'b0;
            end else if (state != S_IDLE) begin
                baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
                if (baud_tick) begin
                    case (state)
                        S_START: tx_q <= shreg[0];
                        S_DATA: begin
                            if (bit_idx == DATA_LAST) begin
                                bit_idx <= '0;
                                tx_q    <= (PARITY != 0) ? par_q : 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shreg   <= shreg >> 1;
                                tx_q    <= shreg[1];
                            end
                        end
                        S_PARITY: tx_q <= 1'b1;
                        S_STOP: begin
                            if (bit_idx != STOP_LAST) bit_idx <= bit_idx + 1'b1;
                        end
                        default: tx_q <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule
